mmio_store_sink: RTL and testbench

//  Responder for the core's data-store interface (MemWrite/DataAddr/WriteData): claims stores
//  to an MMIO window, decodes a TOHOST word into pass/fail/done, buffers CONSOLE words in a FIFO

---
 rtl/mmio_store_sink.sv | 167 ++++++++++++++++
 tb/tb_mmio_store_sink.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_store_sink.sv
// MMIO responder for core stores: TOHOST pass/fail decode plus a console word FIFO.
// Optional watchdog timeout built when WATCHDOG_EN is defined.
module mmio_store_sink #(
  parameter logic [31:0] MMIO_BASE      = 32'h0000_0F00,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAddr,
  input  logic [31:0] WriteData,
  output logic        mmio_hit,
  output logic        con_valid,
  output logic [31:0] con_data,
  input  logic        con_ready,
  output logic [7:0]  drop_cnt,
  output logic        done,
  output logic        pass,
  output logic [30:0] fail_code,
  output logic        timeout
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StRun, StPass, StFail, StTimeout} state_e;

  state_e state_q, state_d;
  logic [30:0] fail_code_q, fail_code_d;

  logic [31:0] offset;
  logic        in_run;
  logic        tohost_wr;
  logic        console_wr;
  logic        wd_expire;

  // Unsigned wrap makes addresses below the base fall outside the window too.
  assign offset     = DataAddr - MMIO_BASE;
  assign mmio_hit   = MemWrite && (offset < 32'd256);
  assign in_run     = (state_q == StRun);
  assign tohost_wr  = mmio_hit && in_run && (offset == 32'h0000_0000);
  assign console_wr = mmio_hit && in_run && (offset == 32'h0000_0004);

`ifdef WATCHDOG_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [WdW-1:0] wd_q, wd_d;

  assign wd_expire = in_run && (wd_q == WdW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wd_d = wd_q;
    if (in_run) begin
      wd_d = wd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end

  assign timeout = (state_q == StTimeout);
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign wd_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

  // TOHOST decode takes priority over a coincident watchdog expiry.
  always_comb begin
    state_d     = state_q;
    fail_code_d = fail_code_q;
    if (tohost_wr && WriteData[0]) begin
      if (WriteData == 32'h0000_0001) begin
        state_d = StPass;
      end else begin
        state_d     = StFail;
        fail_code_d = WriteData[31:1];
      end
    end else if (wd_expire) begin
      state_d = StTimeout;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StRun;
      fail_code_q <= '0;
    end else begin
      state_q     <= state_d;
      fail_code_q <= fail_code_d;
    end
  end

  assign done      = (state_q != StRun);
  assign pass      = (state_q == StPass);
  assign fail_code = fail_code_q;

  // Console FIFO
  logic [31:0]     mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      drop_cnt_q, drop_cnt_d;
  logic            full;
  logic            pop;
  logic            do_push;
  logic            drop;

  assign full    = (cnt_q == CntW'(FIFO_DEPTH));
  assign pop     = con_valid && con_ready;
  assign do_push = console_wr && (!full || pop);
  assign drop    = console_wr && full && !pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({do_push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage needs no reset; cnt_q gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= WriteData;
    end
  end

  assign con_valid = (cnt_q != '0);
  assign con_data  = mem_q[rd_ptr_q];
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_mmio_store_sink.sv
// Directed self-checking bench for mmio_store_sink (TIMEOUT_CYCLES=16).
module tb_mmio_store_sink;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAddr;
  logic [31:0] WriteData;
  logic        mmio_hit;
  logic        con_valid;
  logic [31:0] con_data;
  logic        con_ready;
  logic [7:0]  drop_cnt;
  logic        done;
  logic        pass;
  logic [30:0] fail_code;
  logic        timeout;

  int n_cmp  = 0;
  int n_fail = 0;

  mmio_store_sink #(
    .MMIO_BASE      (32'h0000_0F00),
    .FIFO_DEPTH     (8),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAddr  (DataAddr),
    .WriteData (WriteData),
    .mmio_hit  (mmio_hit),
    .con_valid (con_valid),
    .con_data  (con_data),
    .con_ready (con_ready),
    .drop_cnt  (drop_cnt),
    .done      (done),
    .pass      (pass),
    .fail_code (fail_code),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    MemWrite  = 1'b1;
    DataAddr  = addr;
    WriteData = data;
    tick();
    MemWrite  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({con_valid, done, pass, timeout} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 0000", {con_valid, done, pass, timeout});
    end
    n_cmp++;
    if (drop_cnt !== 8'h00 || fail_code !== 31'd0) begin
      n_fail++;
      $display("FAIL reset_counts: drop %h fail_code %h want 0/0", drop_cnt, fail_code);
    end
  endtask

  task automatic test_pass();
    do_reset();
    MemWrite = 1'b1; DataAddr = 32'hF00; WriteData = 32'h1;
    #1;
    n_cmp++;
    if (mmio_hit !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL pass_pre: hit %b done %b want 1/0", mmio_hit, done);
    end
    tick();
    MemWrite = 1'b0;
    n_cmp++;
    if ({done, pass, timeout} !== 3'b110 || fail_code !== 31'd0) begin
      n_fail++;
      $display("FAIL pass_post: dpt %b fc %h want 110/0", {done, pass, timeout}, fail_code);
    end
    // Window still claimed in a terminal state, but console writes are discarded.
    MemWrite = 1'b1; DataAddr = 32'hF04; WriteData = 32'h55;
    #1;
    n_cmp++;
    if (mmio_hit !== 1'b1) begin
      n_fail++;
      $display("FAIL term_hit: got %b want 1", mmio_hit);
    end
    tick();
    MemWrite = 1'b0;
    n_cmp++;
    if (con_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL term_nopush: con_valid %b want 0", con_valid);
    end
  endtask

  task automatic test_fail();
    do_reset();
    store(32'hF00, 32'h7);
    n_cmp++;
    if ({done, pass, timeout} !== 3'b100 || fail_code !== 31'd3) begin
      n_fail++;
      $display("FAIL fail_code: dpt %b fc %h want 100/3", {done, pass, timeout}, fail_code);
    end
    store(32'hF00, 32'h1);
    n_cmp++;
    if ({done, pass} !== 2'b10 || fail_code !== 31'd3) begin
      n_fail++;
      $display("FAIL fail_hold: dp %b fc %h want 10/3", {done, pass}, fail_code);
    end
  endtask

  task automatic test_fifo_overflow();
    do_reset();
    con_ready = 1'b0;
    for (int i = 0; i < 10; i++) store(32'hF04, i);
    n_cmp++;
    if (drop_cnt !== 8'd2 || con_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_drop: drop %0d valid %b want 2/1", drop_cnt, con_valid);
    end
    con_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (con_valid !== 1'b1 || con_data !== i) begin
        n_fail++;
        $display("FAIL ovf_drain%0d: valid %b data %h want 1/%h", i, con_valid, con_data, i);
      end
      tick();
    end
    n_cmp++;
    if (con_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_empty: con_valid %b want 0", con_valid);
    end
    con_ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    logic [31:0] exp [9];
    do_reset();
    con_ready = 1'b0;
    for (int i = 0; i < 8; i++) store(32'hF04, 32'h10 + i);
    MemWrite = 1'b1; DataAddr = 32'hF04; WriteData = 32'hAA; con_ready = 1'b1;
    tick();
    MemWrite = 1'b0;
    n_cmp++;
    if (drop_cnt !== 8'd0 || con_data !== 32'h11) begin
      n_fail++;
      $display("FAIL pp_same: drop %0d head %h want 0/11", drop_cnt, con_data);
    end
    for (int i = 0; i < 7; i++) exp[i] = 32'h11 + i;
    exp[7] = 32'hAA;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (con_valid !== 1'b1 || con_data !== exp[i]) begin
        n_fail++;
        $display("FAIL pp_drain%0d: valid %b data %h want 1/%h", i, con_valid, con_data, exp[i]);
      end
      tick();
    end
    n_cmp++;
    if (con_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL pp_empty: con_valid %b want 0", con_valid);
    end
    con_ready = 1'b0;
  endtask

  task automatic test_decode_ignore();
    do_reset();
    MemWrite = 1'b1; DataAddr = 32'h100; WriteData = 32'hDEAD;
    #1;
    n_cmp++;
    if (mmio_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL miss_low: hit %b want 0", mmio_hit);
    end
    tick();
    DataAddr = 32'hEFC;
    #1;
    n_cmp++;
    if (mmio_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL miss_below: hit %b want 0", mmio_hit);
    end
    DataAddr = 32'h1000;
    #1;
    n_cmp++;
    if (mmio_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL miss_above: hit %b want 0", mmio_hit);
    end
    DataAddr = 32'hFFC;
    #1;
    n_cmp++;
    if (mmio_hit !== 1'b1) begin
      n_fail++;
      $display("FAIL hit_top: hit %b want 1", mmio_hit);
    end
    tick();
    MemWrite = 1'b0;
    store(32'hF00, 32'h2);
    n_cmp++;
    if ({con_valid, done, pass} !== 3'b000 || drop_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL ignore: vdp %b drop %0d want 000/0", {con_valid, done, pass}, drop_cnt);
    end
  endtask

  task automatic test_watchdog();
`ifdef WATCHDOG_EN
    do_reset();
    repeat (15) tick();
    n_cmp++;
    if ({done, timeout} !== 2'b00) begin
      n_fail++;
      $display("FAIL wd_early: dt %b want 00", {done, timeout});
    end
    tick();
    n_cmp++;
    if ({done, pass, timeout} !== 3'b101) begin
      n_fail++;
      $display("FAIL wd_expire: dpt %b want 101", {done, pass, timeout});
    end
    do_reset();
    repeat (15) tick();
    store(32'hF00, 32'h1);
    n_cmp++;
    if ({done, pass, timeout} !== 3'b110) begin
      n_fail++;
      $display("FAIL wd_priority: dpt %b want 110", {done, pass, timeout});
    end
`else
    do_reset();
    repeat (40) tick();
    n_cmp++;
    if ({done, timeout} !== 2'b00) begin
      n_fail++;
      $display("FAIL wd_absent: dt %b want 00", {done, timeout});
    end
    con_ready = 1'b0;
    for (int i = 0; i < 268; i++) store(32'hF04, i);
    n_cmp++;
    if (drop_cnt !== 8'hFF) begin
      n_fail++;
      $display("FAIL drop_sat: drop %h want ff", drop_cnt);
    end
`endif
  endtask

  task automatic test_midrun_reset();
    do_reset();
    con_ready = 1'b0;
    for (int i = 0; i < 9; i++) store(32'hF04, 32'h100 + i);
    n_cmp++;
    if (drop_cnt !== 8'd1 || con_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mr_pre: drop %0d valid %b want 1/1", drop_cnt, con_valid);
    end
    do_reset();
    n_cmp++;
    if ({con_valid, done, timeout} !== 3'b000 || drop_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL mr_post: vdt %b drop %0d want 000/0", {con_valid, done, timeout}, drop_cnt);
    end
    store(32'hF04, 32'hBEEF);
    n_cmp++;
    if (con_valid !== 1'b1 || con_data !== 32'hBEEF) begin
      n_fail++;
      $display("FAIL mr_push: valid %b data %h want 1/beef", con_valid, con_data);
    end
  endtask

  initial begin
    reset     = 1'b1;
    MemWrite  = 1'b0;
    DataAddr  = '0;
    WriteData = '0;
    con_ready = 1'b0;
    test_reset();
    test_pass();
    test_fail();
    test_fifo_overflow();
    test_full_push_pop();
    test_decode_ignore();
    test_watchdog();
    test_midrun_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
